// File: rtl/yari_pipe_ctrl_pkg.sv
// yari_pipe_ctrl_pkg: shared state encodings and default vectors for the pipeline control unit
package yari_pipe_ctrl_pkg;
    typedef enum logic [1:0] {BOOT_WAIT, BOOT, RUN, IRQ_WAIT} state_t;
    localparam logic [31:0] DEF_BOOT_VECTOR = 32'hBFC00000;
    localparam logic [31:0] DEF_EXC_VECTOR  = 32'hBFC00380;
endpackage

// File: rtl/yari_pipe_ctrl_restart_arb.sv
// yari_pipe_ctrl_restart_arb: lowest-index-first restart select with younger-stage flush mask
module yari_pipe_ctrl_restart_arb #(
    parameter int NSTAGES = 2
) (
    input  logic [NSTAGES-1:0]    src_restart,
    input  logic [32*NSTAGES-1:0] src_restart_pc,
    output logic [NSTAGES-1:0]    grant,
    output logic [31:0]           pc,
    output logic [NSTAGES:0]      flush
);
    always_comb begin
        grant = '0;
        pc = '0;
        flush = '0;
        for (int j = NSTAGES - 1; j >= 0; j--) begin
            if (src_restart[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                pc = src_restart_pc[32*j +: 32];
                flush = {(NSTAGES+1){1'b1}} << (j + 1);
            end
        end
    end
endmodule

// File: rtl/yari_pipe_ctrl.sv
// yari_pipe_ctrl: boot sequencing, restart arbitration and interrupt take for the yari pipeline
module yari_pipe_ctrl
    import yari_pipe_ctrl_pkg::*;
#(
    parameter int          NSTAGES     = 2,
    parameter int          NIRQ        = 6,
    parameter int          BOOT_DELAY  = 8,
    parameter logic [31:0] BOOT_VECTOR = DEF_BOOT_VECTOR,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    kill,
    input  logic [NSTAGES-1:0]      src_restart,
    input  logic [32*NSTAGES-1:0]   src_restart_pc,
    input  logic [NIRQ-1:0]         irq,
    input  logic [NIRQ-1:0]         irq_mask,
    input  logic                    ie,
    input  logic                    irq_ok,
    input  logic [31:0]             irq_epc,
    output logic                    fetch_enable,
    output logic                    restart,
    output logic [31:0]             restart_pc,
    output logic [NSTAGES:0]        flush,
    output logic                    irq_taken,
    output logic                    ie_clear,
    output logic [31:0]             epc,
    output logic [NIRQ-1:0]         cause
);
    localparam int CW = $clog2(BOOT_DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(BOOT_DELAY - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NIRQ-1:0]     irq_q;
    logic [NIRQ-1:0]     pending;
    logic [NSTAGES-1:0]  grant;
    logic [31:0]         arb_pc;
    logic [NSTAGES:0]    arb_flush;
    logic                run;
    logic                any;
    logic                take;

    yari_pipe_ctrl_restart_arb #(.NSTAGES(NSTAGES)) u_arb (
        .src_restart    (src_restart),
        .src_restart_pc (src_restart_pc),
        .grant          (grant),
        .pc             (arb_pc),
        .flush          (arb_flush)
    );

    // kill outranks every source; any source restart outranks an interrupt take
    always_comb begin
        pending = irq_q & irq_mask;
        run = state == RUN || state == IRQ_WAIT;
        any = |grant;
        take = state == RUN && ie && |pending && irq_ok && !kill && !any;
        fetch_enable = run;
        restart = state == BOOT || (run && !kill && (any || take));
        restart_pc = state == BOOT ? BOOT_VECTOR :
                     (!run || kill) ? 32'h0 :
                     any ? arb_pc :
                     take ? EXC_VECTOR : 32'h0;
        flush = (!run || kill) ? {(NSTAGES+1){1'b1}} :
                any ? arb_flush :
                take ? {{NSTAGES{1'b1}}, 1'b0} : '0;
        irq_taken = take;
        ie_clear = take;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= BOOT_WAIT;
            cnt <= '0;
            irq_q <= '0;
            epc <= '0;
            cause <= '0;
        end else begin
            irq_q <= irq;
            if (take) begin
                epc <= irq_epc;
                cause <= pending;
            end
            case (state)
                BOOT_WAIT: begin
                    cnt <= cnt == {CW{1'b1}} ? cnt : cnt + 1'b1;
                    if (cnt == LAST) state <= BOOT;
                end
                BOOT:     state <= RUN;
                RUN:      if (take) state <= IRQ_WAIT;
                IRQ_WAIT: if (!ie) state <= RUN;
            endcase
        end
    end
endmodule
